// File: rtl/du_transmit_pkg.sv
// Shared constants, state encoding and byte-select helper for the debug-unit
// transmit path.
package du_transmit_pkg;

    localparam int NB_DATA     = 32;
    localparam int NB_ADDR     = 7;
    localparam int ADDRWIDTH   = NB_ADDR;
    localparam int N_REGS      = 32;
    localparam int N_MEM       = 128;
    localparam int N_BITS      = 8;
    localparam int N_BYTES     = 4;
    localparam int NB_REG_ADDR = 5;
    localparam int NB_BYTE_SEL = 2;
    localparam int NB_STATE    = 13;

    localparam logic [N_BITS-1:0]      END_MARK = 8'hFF;
    localparam logic [NB_REG_ADDR-1:0] REG_LAST = 5'(N_REGS - 1);
    localparam logic [NB_ADDR-1:0]     MEM_LAST = 7'(N_MEM - 1);

    typedef enum logic [NB_STATE-1:0] {
        S_IDLE     = 13'h0001,
        S_SEND_PC  = 13'h0002,
        S_SEND_CYC = 13'h0004,
        S_REG_RD   = 13'h0008,
        S_REG_LAT  = 13'h0010,
        S_REG_SEND = 13'h0020,
        S_MEM_RD   = 13'h0040,
        S_MEM_LAT  = 13'h0080,
        S_MEM_ADDR = 13'h0100,
        S_MEM_SEND = 13'h0200,
        S_MEM_NEXT = 13'h0400,
        S_SEND_END = 13'h0800,
        S_DONE     = 13'h1000
    } state_t;

    function automatic logic [N_BITS-1:0] byte_sel(input logic [NB_DATA-1:0] word,
                                                   input logic [NB_BYTE_SEL-1:0] idx);
        logic [N_BITS-1:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/du_transmit_if.sv
// Register-file, data-memory and UART-transmitter bus seen by du_transmit.
interface du_transmit_if;
    import du_transmit_pkg::*;

    logic [NB_REG_ADDR-1:0] o_reg_addr;
    logic                   o_reg_rd;
    logic [NB_DATA-1:0]     i_reg_data;
    logic [NB_ADDR-1:0]     o_mem_addr;
    logic                   o_mem_rd;
    logic [NB_DATA-1:0]     i_mem_data;
    logic                   i_mem_dirty;
    logic [N_BITS-1:0]      o_tx_data;
    logic                   o_tx_start;
    logic                   i_tx_done;

    modport master (
        output o_reg_addr, o_reg_rd, o_mem_addr, o_mem_rd, o_tx_data, o_tx_start,
        input  i_reg_data, i_mem_data, i_mem_dirty, i_tx_done
    );

    modport slave (
        input  o_reg_addr, o_reg_rd, o_mem_addr, o_mem_rd, o_tx_data, o_tx_start,
        output i_reg_data, i_mem_data, i_mem_dirty, i_tx_done
    );

endinterface

// File: rtl/du_tx_byte.sv
// One-byte UART send slot: holds the byte, issues a single start pulse and
// reports completion once the transmitter's done arrives after that pulse.
module du_tx_byte
    import du_transmit_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [N_BITS-1:0] i_data,
    input  logic              i_tx_done,
    output logic [N_BITS-1:0] o_tx_data,
    output logic              o_tx_start,
    output logic              o_sent
);

    logic [N_BITS-1:0] r_data;
    logic              r_start;
    logic              r_wait;
    logic              w_sent;

    // A done in the start cycle cannot belong to this byte, so r_start masks it.
    assign w_sent = r_wait & ~r_start & i_tx_done;

    // Byte hold, start pulse and outstanding-send flag.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_data  <= {N_BITS{1'b0}};
            r_start <= 1'b0;
            r_wait  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_start <= 1'b1;
            r_wait  <= 1'b1;
        end else begin
            r_start <= 1'b0;
            if (w_sent) begin
                r_wait <= 1'b0;
            end else begin
                r_wait <= r_wait;
            end
        end
    end

    assign o_tx_data  = r_data;
    assign o_tx_start = r_start;
    assign o_sent     = w_sent;

endmodule

// File: rtl/du_transmit.sv
// Debug-unit dump engine: serializes PC, cycle count, register file and dirty
// memory words into a byte frame ending in END_MARK.
module du_transmit
    import du_transmit_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_ADDR-1:0] i_cycles,
    du_transmit_if.master      bus,
    output logic               o_busy,
    output logic               o_done
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [NB_ADDR-1:0]     r_cycles;
    logic [NB_DATA-1:0]     r_word;
    logic [NB_BYTE_SEL-1:0] r_byte;
    logic [NB_REG_ADDR-1:0] r_reg_addr;
    logic [NB_ADDR-1:0]     r_mem_addr;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_reg_rd;
    logic                   r_mem_rd;
    logic                   w_load;
    logic [N_BITS-1:0]      w_load_data;
    logic                   w_sent;
    logic                   w_last_byte;

    assign w_last_byte = (r_byte == 2'd3);

    // Next-state and byte-load decode; a load always coincides with a start pulse.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_data  = {N_BITS{1'b0}};
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_SEND_PC;
                    w_load       = 1'b1;
                    w_load_data  = N_BITS'(i_pc);
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SEND_PC: begin
                if (w_sent) begin
                    w_next_state = S_SEND_CYC;
                    w_load       = 1'b1;
                    w_load_data  = N_BITS'(r_cycles);
                end else begin
                    w_next_state = S_SEND_PC;
                end
            end
            S_SEND_CYC: begin
                if (w_sent) begin
                    w_next_state = S_REG_RD;
                end else begin
                    w_next_state = S_SEND_CYC;
                end
            end
            S_REG_RD:  w_next_state = S_REG_LAT;
            S_REG_LAT: begin
                w_next_state = S_REG_SEND;
                w_load       = 1'b1;
                w_load_data  = byte_sel(bus.i_reg_data, 2'd0);
            end
            S_REG_SEND: begin
                if (w_sent && w_last_byte) begin
                    if (r_reg_addr == REG_LAST) begin
                        w_next_state = S_MEM_RD;
                    end else begin
                        w_next_state = S_REG_RD;
                    end
                end else if (w_sent) begin
                    w_load      = 1'b1;
                    w_load_data = byte_sel(r_word, r_byte + 2'd1);
                end else begin
                    w_next_state = S_REG_SEND;
                end
            end
            S_MEM_RD:  w_next_state = S_MEM_LAT;
            S_MEM_LAT: begin
                if (bus.i_mem_dirty) begin
                    w_next_state = S_MEM_ADDR;
                    w_load       = 1'b1;
                    w_load_data  = N_BITS'(r_mem_addr);
                end else begin
                    w_next_state = S_MEM_NEXT;
                end
            end
            S_MEM_ADDR: begin
                if (w_sent) begin
                    w_next_state = S_MEM_SEND;
                    w_load       = 1'b1;
                    w_load_data  = byte_sel(r_word, 2'd0);
                end else begin
                    w_next_state = S_MEM_ADDR;
                end
            end
            S_MEM_SEND: begin
                if (w_sent && w_last_byte) begin
                    w_next_state = S_MEM_NEXT;
                end else if (w_sent) begin
                    w_load      = 1'b1;
                    w_load_data = byte_sel(r_word, r_byte + 2'd1);
                end else begin
                    w_next_state = S_MEM_SEND;
                end
            end
            S_MEM_NEXT: begin
                if (r_mem_addr == MEM_LAST) begin
                    w_next_state = S_SEND_END;
                    w_load       = 1'b1;
                    w_load_data  = END_MARK;
                end else begin
                    w_next_state = S_MEM_RD;
                end
            end
            S_SEND_END: begin
                if (w_sent) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_SEND_END;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Status strobes, word latch and address/byte counters.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_reg_rd   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_cycles   <= {NB_ADDR{1'b0}};
            r_word     <= {NB_DATA{1'b0}};
            r_byte     <= 2'd0;
            r_reg_addr <= {NB_REG_ADDR{1'b0}};
            r_mem_addr <= {NB_ADDR{1'b0}};
        end else begin
            r_busy   <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
            r_done   <= (w_next_state == S_DONE);
            r_reg_rd <= (w_next_state == S_REG_RD);
            r_mem_rd <= (w_next_state == S_MEM_RD);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cycles <= i_cycles;
                    end
                end
                S_REG_LAT: begin
                    r_word <= bus.i_reg_data;
                    r_byte <= 2'd0;
                end
                S_REG_SEND: begin
                    if (w_sent) begin
                        r_byte <= r_byte + 2'd1;
                        if (w_last_byte && (r_reg_addr != REG_LAST)) begin
                            r_reg_addr <= r_reg_addr + 5'd1;
                        end
                    end
                end
                S_MEM_LAT: begin
                    r_word <= bus.i_mem_data;
                    r_byte <= 2'd0;
                end
                S_MEM_SEND: begin
                    if (w_sent) begin
                        r_byte <= r_byte + 2'd1;
                    end
                end
                S_MEM_NEXT: begin
                    if (r_mem_addr != MEM_LAST) begin
                        r_mem_addr <= r_mem_addr + 7'd1;
                    end
                end
                S_DONE: begin
                    r_byte     <= 2'd0;
                    r_reg_addr <= {NB_REG_ADDR{1'b0}};
                    r_mem_addr <= {NB_ADDR{1'b0}};
                end
                default: begin
                    r_byte <= r_byte;
                end
            endcase
        end
    end

    du_tx_byte u_tx_byte (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_data     (w_load_data),
        .i_tx_done  (bus.i_tx_done),
        .o_tx_data  (bus.o_tx_data),
        .o_tx_start (bus.o_tx_start),
        .o_sent     (w_sent)
    );

    assign bus.o_reg_addr = r_reg_addr;
    assign bus.o_reg_rd   = r_reg_rd;
    assign bus.o_mem_addr = r_mem_addr;
    assign bus.o_mem_rd   = r_mem_rd;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: doc/du_transmit.md
# du_transmit

Byte-serializing dump engine for the debug unit's UART return path, the transmit-side counterpart of `du_recieve`. When the pipeline stops (halt or single step), `du_transmit` reads state from three sources: the PC, the cycle counter and the register file. It also reads data memory. It streams that state as a fixed-order byte frame through the UART transmitter's start/done handshake, so the host can parse the frame deterministically. The frame ends with a terminator byte.

## Interface
- `NB_DATA`, 32, register/memory word width
- `NB_ADDR`, 7, memory address width (`ADDRWIDTH`)
- `N_REGS`, 32, registers dumped
- `N_MEM`, 128, memory words scanned; must be ≤ 128
- `N_BITS`, 8, UART byte width
- `N_BYTES`, 4, bytes per word
- `END_MARK`, 8'hFF, frame terminator
- `i_clock`  in  1  single clock; all state changes on posedge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_start`  in  1  one-cycle request to dump
- `i_pc`  in  NB_ADDR  program counter
- `i_cycles`  in  NB_ADDR  cycle count
- `o_reg_addr`  out  5  register-file read address
- `o_reg_rd`  out  1  register read strobe
- `i_reg_data`  in  NB_DATA  register data, valid the cycle after `o_reg_rd`
- `o_mem_addr`  out  NB_ADDR  data-memory read address
- `o_mem_rd`  out  1  memory read strobe
- `i_mem_data`  in  NB_DATA  memory data, valid the cycle after `o_mem_rd`
- `i_mem_dirty`  in  1  dirty bit, valid together with `i_mem_data`
- `o_tx_data`  out  N_BITS  byte to send
- `o_tx_start`  out  1  one-cycle start pulse to the UART transmitter
- `i_tx_done`  in  1  one-cycle done pulse from the UART transmitter
- `o_busy`  out  1  high from accepting `i_start` until `o_done`
- `o_done`  out  1  one-cycle pulse at end of frame

## Operation
- **Reset values.** All outputs are 0. The state machine is in IDLE. Address counters are 0.
- **Frame order:**
  - `i_pc` zero-extended to 8 bits.
  - `i_cycles` zero-extended to 8 bits.
  - 32 registers, 4 bytes each, LSB first.
  - For each memory word with dirty=1, in ascending address order: one address byte, then 4 data bytes LSB first.
  - `END_MARK`.
- **Capture.** `i_pc` and `i_cycles` are latched on the cycle `i_start` is accepted. Later changes do not affect the frame.
- **States:**
  - IDLE: go to SEND_PC when `i_start` is seen.
  - SEND_PC, then SEND_CYC.
  - REG_RD: pulse `o_reg_rd`.
  - REG_LAT: latch `i_reg_data`.
  - REG_SEND: 4 bytes. If `o_reg_addr` equals N_REGS-1, go to MEM_RD; otherwise increment `o_reg_addr` and return to REG_RD.
  - MEM_RD: pulse `o_mem_rd`.
  - MEM_LAT: latch data and dirty. If dirty, go to MEM_ADDR; otherwise go to MEM_NEXT.
  - MEM_ADDR: send the address byte.
  - MEM_SEND: 4 bytes.
  - MEM_NEXT: if the address equals N_MEM-1, go to SEND_END; otherwise increment the address and return to MEM_RD.
  - SEND_END, then DONE: pulse `o_done`, clear counters, go to IDLE.
- **Byte send rule.** Each byte-send state does the following:
  - Drives `o_tx_data`.
  - Pulses `o_tx_start` for exactly one cycle, on the first cycle in the state.
  - Holds `o_tx_data` stable until `i_tx_done`.
  - Advances on `i_tx_done`.
- **Byte counter.** A 2-bit counter selects `word[8*k +: 8]`. It wraps 3→0 at the end of each word.
- **Address wrap.** The memory address counter is NB_ADDR bits wide. It never wraps inside a frame, because the N_MEM-1 compare terminates the scan. `END_MARK` is unambiguous because every address is < 128.
- **Boundary conditions:**
  - `i_start` while `o_busy` is ignored.
  - `i_tx_done` with no start outstanding, including in IDLE, is ignored.
  - `i_tx_done` in the same cycle as `o_tx_start` is ignored; the transmitter cannot complete in 0 cycles.
  - Reset asserted mid-frame returns immediately to IDLE with all outputs 0. A byte already in flight in the UART finishes, and its done pulse is ignored.
- **Dirty bit.** `du_transmit` does not clear dirty bits.

## Timing
- `i_start` at cycle t gives `o_busy`=1 and the `o_tx_start` for the PC byte at cycle t+1.
- Next byte: `o_tx_start` comes 1 cycle after the `i_tx_done` of the previous byte when staying in the same send context. Word boundaries add 2 cycles (RD, LAT).
- A clean memory word costs 3 cycles (RD, LAT, NEXT) and sends no bytes.
- Bytes per frame = 2 + 4·N_REGS + 5·D + 1, where D is the dirty word count. For the defaults with D=0, that is 131.
- `o_done` comes 1 cycle after the `i_tx_done` of `END_MARK`. `o_busy` drops in the same cycle as `o_done`.

## Structure
- **Shared parameters package:**
  - state encodings (one-hot, NB_STATE-style localparams)
  - `END_MARK`
  - `N_BYTES`
  - `ADDRWIDTH`
  - UART byte width
- **Sub-module `du_tx_byte`:**
  - byte hold register
  - single-pulse `o_tx_start` generation
  - wait-for-done flag
  - `o_sent` strobe back to the main state machine
- **Top state machine:** word latch, register and memory counters, byte counter.

## Test plan
- **No dirty words.** Stimulus: `i_pc`=0x12, `i_cycles`=0x34, register r=r·0x01010101, all memory clean, UART model with 10-cycle done latency. Required: 131 bytes: 0x12, 0x34, then for each register r the byte value r four times, then 0xFF. `o_done` pulses once.
- **Dirty words.** Stimulus: dirty words at addresses 3 (0xDEADBEEF) and 127 (0x00000001). Required, after the registers: 03 EF BE AD DE 7F 01 00 00 00 FF.
- **Busy start.** Stimulus: `i_start` re-pulsed while busy, plus a spurious `i_tx_done` in IDLE. Required: frame unchanged, no extra `o_tx_start`.
- **Reset mid-frame.** Stimulus: `i_reset` low during the register 10 bytes. Required: outputs are 0 asynchronously. A new `i_start` produces a full frame starting with the PC byte.
- **Handshake and latency checks:**
  - `o_tx_start` is never high on two consecutive cycles.
  - `o_tx_data` is stable from start to done.
  - PC start at t+1.
- **Input capture.** Stimulus: change `i_pc` after start. Required: the sent PC byte equals the value captured at start.
